// File: rtl/image_line_sched.sv
// rtl/image_line_sched.sv - per-line AXI write burst scheduler for one image frame
//
// Walks a frame line by line: waits for a buffered line, starts one AXI master
// burst at the line's address, waits for completion, then steps the address by
// the stride. Errors and timeouts abort the frame and raise a sticky flag.
//
// Optional feature macro: IMG_SCHED_PINGPONG_EN (adds a second frame buffer base
// and alternates between the two buffers on every completed frame).
//
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   CFG_BASE_ADDR           frame buffer 0 base address
//   CFG_BASE_ADDR1          frame buffer 1 base address (ping-pong build only)
//   CFG_STRIDE              byte offset between consecutive lines
//   CFG_LINES               lines per frame (0 = frame start ignored)
//   FRAME_START             single-cycle pulse to begin a frame
//   LINE_READY              a full line is buffered for the AXI master
//   LINE_ACK                pulse: buffered line consumed or discarded
//   TXN_ADDR                burst target address
//   INIT_AXI_TXN            single-cycle burst start pulse
//   TXN_DONE, TXN_ERROR     burst completion and error status
//   BUSY                    frame in progress
//   FRAME_DONE              pulse: last line of the frame written
//   ERR_STICKY, ERR_CLR     sticky error flag and its clear
//   LINE_IDX                index of the current line
//   BUF_SEL                 active frame buffer (ping-pong build only)

module image_line_sched #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 11,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] CFG_BASE_ADDR,
`ifdef IMG_SCHED_PINGPONG_EN
    input  logic [ADDR_W-1:0] CFG_BASE_ADDR1,
    output logic              BUF_SEL,
`endif
    input  logic [15:0]       CFG_STRIDE,
    input  logic [LINE_W-1:0] CFG_LINES,
    input  logic              FRAME_START,
    input  logic              LINE_READY,
    output logic              LINE_ACK,
    output logic [ADDR_W-1:0] TXN_ADDR,
    output logic              INIT_AXI_TXN,
    input  logic              TXN_DONE,
    input  logic              TXN_ERROR,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              ERR_STICKY,
    input  logic              ERR_CLR,
    output logic [LINE_W-1:0] LINE_IDX
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        ISSUE,
        WAIT_DONE,
        ADVANCE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [LINE_W-1:0] lines_q;
    logic [15:0]       stride_q;
    logic [LINE_W-1:0] line_idx;
    logic [ADDR_W-1:0] txn_addr;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              err_sticky;
    logic              line_ack;

    logic              frame_go;
    logic              overrun;
    logic              last_line;
    logic              timed_out;
    logic              done_ok;
    logic              abort;
    logic              frame_done;
    logic [ADDR_W-1:0] base_sel;

`ifdef IMG_SCHED_PINGPONG_EN
    logic              buf_sel;
    assign base_sel = buf_sel ? CFG_BASE_ADDR1 : CFG_BASE_ADDR;
    assign BUF_SEL  = buf_sel;
`else
    assign base_sel = CFG_BASE_ADDR;
`endif

    assign frame_go  = FRAME_START && (CFG_LINES != '0);
    assign overrun   = FRAME_START && (state != IDLE);
    // lines_q is never zero inside a frame, so lines_q-1 cannot underflow there
    assign last_line = (line_idx == lines_q - 1'b1);
    // Fires after TIMEOUT_CYC full cycles spent in WAIT_DONE
    assign timed_out = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next = state;
        done_ok    = 1'b0;
        abort      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_go) begin
                    state_next = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (LINE_READY) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A completion in the same cycle as the timeout still counts
                if (TXN_DONE) begin
                    if (TXN_ERROR) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        done_ok    = 1'b1;
                        state_next = ADVANCE;
                    end
                end else if (timed_out) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            ADVANCE: begin
                if (last_line) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_LINE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lines_q    <= '0;
            stride_q   <= '0;
            line_idx   <= '0;
            txn_addr   <= '0;
            tmo_cnt    <= '0;
            err_sticky <= 1'b0;
            line_ack   <= 1'b0;
        end else begin
            line_ack <= done_ok || abort;

            // Config is captured only here; later input changes are invisible
            if ((state == IDLE) && frame_go) begin
                lines_q  <= CFG_LINES;
                stride_q <= CFG_STRIDE;
                line_idx <= '0;
                txn_addr <= base_sel;
            end

            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT_DONE) && !timed_out) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Address wraps modulo 2^ADDR_W by plain truncation
            if ((state == ADVANCE) && !last_line) begin
                line_idx <= line_idx + 1'b1;
                txn_addr <= txn_addr + ADDR_W'(stride_q);
            end

            // Setting wins over a simultaneous clear
            if (abort || overrun) begin
                err_sticky <= 1'b1;
            end else if (ERR_CLR) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef IMG_SCHED_PINGPONG_EN
    // Toggles only on a completed frame; aborted frames reuse the same buffer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            buf_sel <= 1'b0;
        end else if (frame_done) begin
            buf_sel <= ~buf_sel;
        end
    end
`endif

    assign INIT_AXI_TXN = (state == ISSUE);
    assign BUSY         = (state != IDLE);
    assign FRAME_DONE   = frame_done;
    assign LINE_ACK     = line_ack;
    assign ERR_STICKY   = err_sticky;
    assign LINE_IDX     = line_idx;
    assign TXN_ADDR     = txn_addr;

endmodule

// File: tb/tb_image_line_sched.sv
// tb/tb_image_line_sched.sv - scoreboard bench for image_line_sched

module tb_image_line_sched;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 11;
    localparam int TMO    = 16;

    logic              ACLK;
    logic              ARESET;
    logic [ADDR_W-1:0] CFG_BASE_ADDR;
`ifdef IMG_SCHED_PINGPONG_EN
    logic [ADDR_W-1:0] CFG_BASE_ADDR1;
    logic              BUF_SEL;
`endif
    logic [15:0]       CFG_STRIDE;
    logic [LINE_W-1:0] CFG_LINES;
    logic              FRAME_START;
    logic              LINE_READY;
    logic              LINE_ACK;
    logic [ADDR_W-1:0] TXN_ADDR;
    logic              INIT_AXI_TXN;
    logic              TXN_DONE;
    logic              TXN_ERROR;
    logic              BUSY;
    logic              FRAME_DONE;
    logic              ERR_STICKY;
    logic              ERR_CLR;
    logic [LINE_W-1:0] LINE_IDX;

    image_line_sched #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .CFG_BASE_ADDR  (CFG_BASE_ADDR),
`ifdef IMG_SCHED_PINGPONG_EN
        .CFG_BASE_ADDR1 (CFG_BASE_ADDR1),
        .BUF_SEL        (BUF_SEL),
`endif
        .CFG_STRIDE     (CFG_STRIDE),
        .CFG_LINES      (CFG_LINES),
        .FRAME_START    (FRAME_START),
        .LINE_READY     (LINE_READY),
        .LINE_ACK       (LINE_ACK),
        .TXN_ADDR       (TXN_ADDR),
        .INIT_AXI_TXN   (INIT_AXI_TXN),
        .TXN_DONE       (TXN_DONE),
        .TXN_ERROR      (TXN_ERROR),
        .BUSY           (BUSY),
        .FRAME_DONE     (FRAME_DONE),
        .ERR_STICKY     (ERR_STICKY),
        .ERR_CLR        (ERR_CLR),
        .LINE_IDX       (LINE_IDX)
    );

    localparam logic [ADDR_W-1:0] BASE1 = 32'h2000_0000;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ack   = 0;
    int n_fdone = 0;
    int n_init  = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    int                exp_idx_q[$];
    bit                model_buf;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (LINE_ACK)     n_ack   <= n_ack + 1;
        if (FRAME_DONE)   n_fdone <= n_fdone + 1;
        if (INIT_AXI_TXN) n_init  <= n_init + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [15:0] stride,
                               input int lines, input int npush);
        logic [ADDR_W-1:0] a;
        a = base;
`ifdef IMG_SCHED_PINGPONG_EN
        if (model_buf) a = BASE1;
`endif
        for (int i = 0; i < npush; i++) begin
            exp_addr_q.push_back(a);
            exp_idx_q.push_back(i);
            a = a + ADDR_W'(stride);
        end
        CFG_BASE_ADDR = base;
        CFG_STRIDE    = stride;
        CFG_LINES     = LINE_W'(lines);
        FRAME_START   = 1'b1;
        tick();
        FRAME_START   = 1'b0;
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (INIT_AXI_TXN) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            check_eq("init_timeout", 64'(0), 64'(1));
        end else if (exp_addr_q.size() == 0) begin
            check_eq("addr_q_empty", 64'(1), 64'(0));
        end else begin
            check_eq("txn_addr", 64'(TXN_ADDR), 64'(exp_addr_q.pop_front()));
            check_eq("line_idx", 64'(LINE_IDX), 64'(exp_idx_q.pop_front()));
        end
    endtask

    task automatic serve_line(input int delay, input bit err);
        bit ok;
        wait_init(ok);
        if (ok) begin
            repeat (delay) tick();
            TXN_DONE  = 1'b1;
            TXN_ERROR = err;
            tick();
            TXN_DONE  = 1'b0;
            TXN_ERROR = 1'b0;
        end
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        int a0, f0, i0, cyc;
        bit ok;

        ARESET        = 1'b1;
        CFG_BASE_ADDR = '0;
`ifdef IMG_SCHED_PINGPONG_EN
        CFG_BASE_ADDR1 = BASE1;
`endif
        CFG_STRIDE    = '0;
        CFG_LINES     = '0;
        FRAME_START   = 1'b0;
        LINE_READY    = 1'b1;
        TXN_DONE      = 1'b0;
        TXN_ERROR     = 1'b0;
        ERR_CLR       = 1'b0;
        model_buf     = 1'b0;
        repeat (3) tick();

        check_eq("rst_busy",  64'(BUSY), 64'(0));
        check_eq("rst_idx",   64'(LINE_IDX), 64'(0));
        check_eq("rst_addr",  64'(TXN_ADDR), 64'(0));
        check_eq("rst_err",   64'(ERR_STICKY), 64'(0));
        check_eq("rst_init",  64'(INIT_AXI_TXN), 64'(0));
        check_eq("rst_ack",   64'(LINE_ACK), 64'(0));
        check_eq("rst_fdone", 64'(FRAME_DONE), 64'(0));
        ARESET = 1'b0;
        tick();

        // Normal three-line frame
        a0 = n_ack; f0 = n_fdone;
        start_frame(32'h1000_0000, 16'h0500, 3, 3);
        for (int i = 0; i < 3; i++) serve_line(5, 1'b0);
        repeat (3) tick();
        model_buf = ~model_buf;
        check_eq("norm_acks",  64'(n_ack - a0), 64'(3));
        check_eq("norm_fdone", 64'(n_fdone - f0), 64'(1));
        check_eq("norm_busy",  64'(BUSY), 64'(0));
        check_eq("norm_err",   64'(ERR_STICKY), 64'(0));

        // Error on second line aborts the frame
        a0 = n_ack; f0 = n_fdone;
        start_frame(32'h3000_0000, 16'h0100, 4, 2);
        serve_line(3, 1'b0);
        serve_line(3, 1'b1);
        check_eq("err_busy",  64'(BUSY), 64'(0));
        check_eq("err_flag",  64'(ERR_STICKY), 64'(1));
        repeat (2) tick();
        check_eq("err_acks",  64'(n_ack - a0), 64'(2));
        check_eq("err_fdone", 64'(n_fdone - f0), 64'(0));
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check_eq("err_clr",   64'(ERR_STICKY), 64'(0));

        // Missing completion times out after TMO cycles in WAIT_DONE
        a0 = n_ack; f0 = n_fdone;
        start_frame(32'h4000_0000, 16'h0010, 2, 1);
        wait_init(ok);
        tick();
        cyc = 0;
        while (!ERR_STICKY && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq("tmo_cycles", 64'(cyc), 64'(16));
        check_eq("tmo_busy",   64'(BUSY), 64'(0));
        repeat (2) tick();
        check_eq("tmo_acks",   64'(n_ack - a0), 64'(1));
        check_eq("tmo_fdone",  64'(n_fdone - f0), 64'(0));
        // Stray completion while idle does nothing
        a0 = n_ack;
        TXN_DONE = 1'b1;
        tick();
        TXN_DONE = 1'b0;
        repeat (2) tick();
        check_eq("stray_acks", 64'(n_ack - a0), 64'(0));
        check_eq("stray_busy", 64'(BUSY), 64'(0));
        clear_err();

        // Overrun with mid-frame config change; frame must finish unchanged
        a0 = n_ack; f0 = n_fdone;
        start_frame(32'h5000_0000, 16'h0200, 2, 2);
        wait_init(ok);
        tick();
        FRAME_START   = 1'b1;
        CFG_BASE_ADDR = 32'h6000_0000;
        CFG_STRIDE    = 16'h0040;
        CFG_LINES     = LINE_W'(7);
        tick();
        FRAME_START   = 1'b0;
        check_eq("ovr_err",  64'(ERR_STICKY), 64'(1));
        check_eq("ovr_busy", 64'(BUSY), 64'(1));
        TXN_DONE = 1'b1;
        tick();
        TXN_DONE = 1'b0;
        serve_line(2, 1'b0);
        repeat (3) tick();
        model_buf = ~model_buf;
        check_eq("ovr_acks",  64'(n_ack - a0), 64'(2));
        check_eq("ovr_fdone", 64'(n_fdone - f0), 64'(1));
        clear_err();

        // Zero-line frame start is ignored
        i0 = n_init;
        start_frame(32'h7000_0000, 16'h0100, 0, 0);
        repeat (5) tick();
        check_eq("zero_init", 64'(n_init - i0), 64'(0));
        check_eq("zero_busy", 64'(BUSY), 64'(0));
        check_eq("zero_err",  64'(ERR_STICKY), 64'(0));

        // Address wrap across 2^32
        f0 = n_fdone;
        start_frame(32'hFFFF_FC00, 16'h0400, 2, 2);
        for (int i = 0; i < 2; i++) serve_line(4, 1'b0);
        repeat (3) tick();
        model_buf = ~model_buf;
        check_eq("wrap_fdone", 64'(n_fdone - f0), 64'(1));

        // Reset while a burst is in flight
        start_frame(32'h8000_0000, 16'h0100, 3, 1);
        wait_init(ok);
        tick();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        check_eq("pre_rst_err", 64'(ERR_STICKY), 64'(1));
        ARESET = 1'b1;
        tick();
        check_eq("mid_rst_busy",  64'(BUSY), 64'(0));
        check_eq("mid_rst_idx",   64'(LINE_IDX), 64'(0));
        check_eq("mid_rst_addr",  64'(TXN_ADDR), 64'(0));
        check_eq("mid_rst_err",   64'(ERR_STICKY), 64'(0));
        check_eq("mid_rst_ack",   64'(LINE_ACK), 64'(0));
        check_eq("mid_rst_init",  64'(INIT_AXI_TXN), 64'(0));
        check_eq("mid_rst_fdone", 64'(FRAME_DONE), 64'(0));
        model_buf = 1'b0;
        ARESET = 1'b0;
        tick();
`ifdef IMG_SCHED_PINGPONG_EN
        check_eq("rst_bufsel", 64'(BUF_SEL), 64'(0));
`endif

        // Fresh frame after reset
        f0 = n_fdone;
        start_frame(32'h9000_0000, 16'h0020, 1, 1);
        serve_line(2, 1'b0);
        repeat (3) tick();
        model_buf = ~model_buf;
        check_eq("post_rst_fdone", 64'(n_fdone - f0), 64'(1));
`ifdef IMG_SCHED_PINGPONG_EN
        check_eq("pp_bufsel1", 64'(BUF_SEL), 64'(1));
        start_frame(32'hA000_0000, 16'h0010, 1, 1);
        serve_line(2, 1'b0);
        repeat (3) tick();
        model_buf = ~model_buf;
        check_eq("pp_bufsel0", 64'(BUF_SEL), 64'(0));
`endif

        check_eq("exp_q_left", 64'(exp_addr_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_line_sched.md
IMAGE_LINE_SCHED -- requirements
Module: image_line_sched

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32: AXI write address width.
- REQ-002 SHALL have parameter LINE_W, default 11: line counter width (max 2047 lines).
- REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles to wait for TXN_DONE.
- REQ-004 SHALL have port ACLK, input, 1: the single clock; all logic on rising edge.
- REQ-005 SHALL have port ARESET, input, 1: reset, synchronous, active-high.
- REQ-006 SHALL have port CFG_BASE_ADDR, input, ADDR_W: frame buffer 0 base address.
- REQ-007 SHALL have port CFG_STRIDE, input, 16: byte offset between consecutive lines.
- REQ-008 SHALL have port CFG_LINES, input, LINE_W: lines per frame.
- REQ-009 SHALL have port FRAME_START, input, 1: single-cycle pulse to begin a frame.
- REQ-010 SHALL have port LINE_READY, input, 1: a full line is buffered for the AXI master.
- REQ-011 SHALL have port LINE_ACK, output, 1: single-cycle pulse, buffered line consumed or discarded.
- REQ-012 SHALL have port TXN_ADDR, output, ADDR_W: target address for the AXI master burst.
- REQ-013 SHALL have port INIT_AXI_TXN, output, 1: single-cycle start pulse to the AXI master.
- REQ-014 SHALL have ports TXN_DONE and TXN_ERROR, inputs, 1 each: AXI master completion and error status.
- REQ-015 SHALL have ports BUSY, FRAME_DONE, ERR_STICKY, outputs, 1 each, and ERR_CLR, input, 1.
- REQ-016 SHALL have port LINE_IDX, output, LINE_W: index of the current line.

Function
- REQ-017 SHALL implement states IDLE, WAIT_LINE, ISSUE, WAIT_DONE, ADVANCE.
- REQ-018 IDLE: FRAME_START with CFG_LINES!=0 SHALL latch the config, set LINE_IDX=0, set TXN_ADDR=base, and go to WAIT_LINE; FRAME_START with CFG_LINES=0 SHALL be ignored.
- REQ-019 WAIT_LINE: LINE_READY=1 SHALL go to ISSUE; INIT_AXI_TXN SHALL be high for exactly the one cycle spent in ISSUE, one cycle after LINE_READY is sampled.
- REQ-020 ISSUE SHALL go unconditionally to WAIT_DONE and clear the timeout counter.
- REQ-021 WAIT_DONE: TXN_DONE=1 with TXN_ERROR=0 SHALL go to ADVANCE with one LINE_ACK pulse.
- REQ-022 ADVANCE: if LINE_IDX==latched lines-1, SHALL pulse FRAME_DONE and go to IDLE; otherwise SHALL increment LINE_IDX, add the latched stride to TXN_ADDR (modulo 2^ADDR_W, wrap permitted), and return to WAIT_LINE.
- REQ-023 WAIT_DONE: TXN_DONE=1 with TXN_ERROR=1, or the counter reaching TIMEOUT_CYC, SHALL set ERR_STICKY, pulse LINE_ACK, skip FRAME_DONE, and go to IDLE (frame aborted).
- REQ-024 FRAME_START outside IDLE SHALL be ignored and SHALL set ERR_STICKY (overrun).
- REQ-025 ERR_CLR SHALL clear ERR_STICKY; a set condition in the same cycle SHALL win.
- REQ-026 Config inputs SHALL be sampled only on an accepted FRAME_START; mid-frame changes SHALL have no effect.
- REQ-027 BUSY SHALL be 1 in every state except IDLE.
- REQ-028 TXN_DONE outside WAIT_DONE SHALL be ignored.

Reset
- REQ-029 ARESET=1 SHALL force IDLE, LINE_IDX=0, TXN_ADDR=0, ERR_STICKY=0, and all pulse outputs and BUSY to 0, overriding any state, including an in-flight transaction.

Configuration
- REQ-030 Macro IMG_SCHED_PINGPONG_EN defined: SHALL add input CFG_BASE_ADDR1 (ADDR_W) and output BUF_SEL (1, reset 0); each accepted frame SHALL use buffer BUF_SEL; BUF_SEL SHALL toggle only on FRAME_DONE and SHALL not toggle on an aborted frame.
- REQ-031 Macro undefined: neither port SHALL exist, and every frame SHALL use CFG_BASE_ADDR.

Verification
- REQ-032 base=0x1000_0000, stride=0x500, lines=3, LINE_READY held, TXN_DONE 5 cycles after each INIT -> TXN_ADDR 0x1000_0000/0x1000_0500/0x1000_0A00, 3 LINE_ACK pulses, 1 FRAME_DONE.
- REQ-033 lines=4, TXN_ERROR=1 on line 2 -> ERR_STICKY=1, 2 LINE_ACK pulses, no FRAME_DONE, BUSY=0 the next cycle.
- REQ-034 TXN_DONE never returned, TIMEOUT_CYC=16 -> ERR_STICKY set 16 cycles after INIT, state IDLE.
- REQ-035 FRAME_START during WAIT_DONE -> ignored, ERR_STICKY=1, frame completes normally; lines=0 FRAME_START -> no INIT_AXI_TXN pulse.
- REQ-036 base=0xFFFF_FC00, stride=0x400, lines=2 -> second TXN_ADDR=0x0000_0000; ARESET asserted in WAIT_DONE -> all outputs at reset values the next cycle.
- REQ-037 With IMG_SCHED_PINGPONG_EN, two complete frames -> bases CFG_BASE_ADDR then CFG_BASE_ADDR1, BUF_SEL 0 -> 1 -> 0.
